// File: rtl/sevseg_scan_ctrl.sv
// Purpose : two-digit PmodSSD refresh scheduler with anti-ghost blanking, PWM brightness and
//           frame-aligned double-buffered pattern updates.
// Latency : all outputs registered, 1 cycle behind the internal state; no backpressure (LOAD always accepted).
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_enable     1 = scan the display, 0 = dark/idle
//   i_seg0_in    digit0 pattern {g,f,e,d,c,b,a}, 1 = lit
//   i_seg1_in    digit1 pattern, same encoding
//   i_load       1-cycle strobe capturing both patterns into the shadow registers
//   i_bright     PWM on-time per 2^PWM_BITS phase, sampled every cycle
//   o_load_ack   1-cycle pulse once a captured pattern has become live
//   o_frame_tick 1-cycle pulse at the start of every frame
//   o_pmod       {digit_sel, seg[6:0]} to the Pmod pins
module sevseg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 6000,
    parameter int BLANK_CYCLES = 60,
    parameter int PWM_BITS     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [6:0]          i_seg0_in,
    input  logic [6:0]          i_seg1_in,
    input  logic                i_load,
    input  logic [PWM_BITS-1:0] i_bright,
    output logic                o_load_ack,
    output logic                o_frame_tick,
    output logic [7:0]          o_pmod
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BLANK0 = 3'd1,
        S_SHOW0  = 3'd2,
        S_BLANK1 = 3'd3,
        S_SHOW1  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_slot_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [6:0]          r_shadow0;
    logic [6:0]          r_shadow1;
    logic [6:0]          r_active0;
    logic [6:0]          r_active1;
    logic                r_pending;

    logic                w_enter_blank;
    logic                w_boundary;
    logic                w_xfer;
    logic                w_frame_start;
    logic                w_lit;
    logic                w_digit;
    logic [6:0]          w_seg;
    logic [7:0]          w_pmod;

    // Next-state logic. ENABLE low overrides everything and parks the scanner.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_enable)                 w_next = S_BLANK0;
            S_BLANK0: if (r_slot_cnt == BLANK_LAST) w_next = S_SHOW0;
            S_SHOW0:  if (r_slot_cnt == SLOT_LAST)  w_next = S_BLANK1;
            S_BLANK1: if (r_slot_cnt == BLANK_LAST) w_next = S_SHOW1;
            S_SHOW1:  if (r_slot_cnt == SLOT_LAST)  w_next = S_BLANK0;
            default:                                w_next = S_IDLE;
        endcase
        if (!i_enable) begin
            w_next = S_IDLE;
        end
    end

    assign w_enter_blank = ((w_next == S_BLANK0) || (w_next == S_BLANK1)) && (w_next != r_state);
    assign w_frame_start = (w_next == S_BLANK0) && (r_state != S_BLANK0);

    // Patterns may only change while nothing is being shown: in IDLE, or on the
    // first cycle of BLANK0. Slot count 0 occurs once per BLANK0 visit.
    assign w_boundary = (r_state == S_IDLE) ||
                        ((r_state == S_BLANK0) && (r_slot_cnt == '0));
    assign w_xfer     = w_boundary && (i_load || r_pending);

    // Segment drive for the current cycle, registered below.
    assign w_lit = (r_pwm_cnt < i_bright);

    always_comb begin
        w_digit = 1'b0;
        w_seg   = 7'h00;
        case (r_state)
            S_BLANK0: w_digit = 1'b0;
            S_SHOW0: begin
                w_digit = 1'b0;
                w_seg   = w_lit ? r_active0 : 7'h00;
            end
            S_BLANK1: w_digit = 1'b1;
            S_SHOW1: begin
                w_digit = 1'b1;
                w_seg   = w_lit ? r_active1 : 7'h00;
            end
            default: begin
                w_digit = 1'b0;
                w_seg   = 7'h00;
            end
        endcase
    end

    // Gating with ENABLE makes the pins go dark on the cycle right after ENABLE falls.
    assign w_pmod = i_enable ? {w_digit, w_seg} : 8'h00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_slot_cnt   <= '0;
            r_pwm_cnt    <= '0;
            r_shadow0    <= 7'h00;
            r_shadow1    <= 7'h00;
            r_active0    <= 7'h00;
            r_active1    <= 7'h00;
            r_pending    <= 1'b0;
            o_load_ack   <= 1'b0;
            o_frame_tick <= 1'b0;
            o_pmod       <= 8'h00;
        end else begin
            r_state <= w_next;

            // The slot counter spans blank+show of one digit, so it keeps counting
            // across BLANKn->SHOWn and only restarts at the next blank.
            if ((w_next == S_IDLE) || w_enter_blank) begin
                r_slot_cnt <= '0;
                r_pwm_cnt  <= '0;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
                r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            end

            // Off-boundary loads park in the shadow; repeated loads just overwrite it.
            if (i_load && !w_boundary) begin
                r_shadow0 <= i_seg0_in;
                r_shadow1 <= i_seg1_in;
                r_pending <= 1'b1;
            end

            // A load on the boundary cycle itself bypasses the shadow.
            if (w_xfer) begin
                r_active0 <= i_load ? i_seg0_in : r_shadow0;
                r_active1 <= i_load ? i_seg1_in : r_shadow1;
                r_pending <= 1'b0;
            end

            o_load_ack   <= w_xfer;
            o_frame_tick <= w_frame_start;
            o_pmod       <= w_pmod;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Purpose : directed self-checking bench for sevseg_scan_ctrl (SLOT=32, BLANK=4, PWM_BITS=2).
// Latency : samples on the falling edge, drives inputs right after sampling.
// Backpressure: none; the bench tracks the frame phase (0 = FRAME_TICK cycle) itself.
module tb_sevseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seg0 = 7'h00;
    logic [6:0] seg1 = 7'h00;
    logic [1:0] bright = 2'd3;
    logic       load_ack;
    logic       frame_tick;
    logic [7:0] pmod;

    int         ph = 0;
    int         checks = 0;
    int         errors = 0;
    logic [6:0] ea0 = 7'h00;
    logic [6:0] ea1 = 7'h00;
    logic [1:0] ebr = 2'd3;
    logic       eack;
    logic [7:0] ep;

    sevseg_scan_ctrl #(
        .SLOT_CYCLES (32),
        .BLANK_CYCLES(4),
        .PWM_BITS    (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_seg0_in   (seg0),
        .i_seg1_in   (seg1),
        .i_load      (load),
        .i_bright    (bright),
        .o_load_ack  (load_ack),
        .o_frame_tick(frame_tick),
        .o_pmod      (pmod)
    );

    always #5 clk = ~clk;

    // Expected PMOD in frame phase p: the pins show the state of phase p-1.
    // Phases 0..3 blank0, 4..31 show0, 32..35 blank1, 36..63 show1; the PWM
    // phase restarts at each blank, so it is (slot position mod 4).
    function automatic logic [7:0] exp_pmod(int p, bit fst, logic [6:0] a0, logic [6:0] a1, logic [1:0] br);
        int   m;
        int   s;
        logic dsel;
        logic lit;
        if (fst && p == 0) return 8'h00;
        m    = (p + 63) % 64;
        s    = m % 32;
        dsel = (m >= 32);
        lit  = (s >= 4) && ((s % 4) < int'(br));
        return {dsel, lit ? (dsel ? a1 : a0) : 7'h00};
    endfunction

    task automatic cyc();
        @(negedge clk);
        ph = (ph + 1) % 64;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #12;
        checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL reset_pmod got %h exp 00", pmod); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", load_ack); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL idle_pmod got %h exp 00", pmod); end
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL idle_tick got %b exp 0", frame_tick); end
        end
    endtask

    task automatic test_scan_blank_patterns();
        enable = 1'b1;
        ph = 63;
        for (int i = 0; i < 128; i++) begin
            cyc();
            ep = exp_pmod(ph, i == 0, 7'h00, 7'h00, 2'd3);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t1_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t1_tick ph=%0d got %b", ph, frame_tick); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL t1_ack ph=%0d got %b exp 0", ph, load_ack); end
        end
    endtask

    task automatic test_load_pending();
        ea0 = 7'h00; ea1 = 7'h00;
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (i >= 65) begin ea0 = 7'h3F; ea1 = 7'h06; end
            eack = (i == 65);
            ep = exp_pmod(ph, 1'b0, ea0, ea1, 2'd3);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t2_pmod i=%0d got %h exp %h", i, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t2_tick i=%0d got %b", i, frame_tick); end
            checks++; if (load_ack !== eack) begin errors++; $display("FAIL t2_ack i=%0d got %b exp %b", i, load_ack, eack); end
            load = (i == 40);
            if (i == 40) begin seg0 = 7'h3F; seg1 = 7'h06; end
        end
    endtask

    task automatic test_double_load();
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (i >= 65) begin ea0 = 7'h5B; ea1 = 7'h5B; end
            eack = (i == 65);
            ep = exp_pmod(ph, 1'b0, ea0, ea1, 2'd3);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t3_pmod i=%0d got %h exp %h", i, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t3_tick i=%0d got %b", i, frame_tick); end
            checks++; if (load_ack !== eack) begin errors++; $display("FAIL t3_ack i=%0d got %b exp %b", i, load_ack, eack); end
            load = (i == 10) || (i == 40);
            if (i == 10) begin seg0 = 7'h7F; seg1 = 7'h7F; end
            if (i == 40) begin seg0 = 7'h5B; seg1 = 7'h5B; end
        end
    endtask

    task automatic test_back_to_back_boundary_load();
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (i >= 1) begin ea0 = 7'h66; ea1 = 7'h6D; end
            eack = (i == 1);
            ep = exp_pmod(ph, 1'b0, ea0, ea1, 2'd3);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t4_pmod i=%0d got %h exp %h", i, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t4_tick i=%0d got %b", i, frame_tick); end
            checks++; if (load_ack !== eack) begin errors++; $display("FAIL t4_ack i=%0d got %b exp %b", i, load_ack, eack); end
            load = (i == 0);
            if (i == 0) begin seg0 = 7'h66; seg1 = 7'h6D; end
        end
    endtask

    task automatic test_bright_enable();
        bright = 2'd0; ebr = 2'd0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            ep = exp_pmod(ph, 1'b0, ea0, ea1, ebr);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t5_dark_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
        end
        bright = 2'd3; ebr = 2'd3;
        for (int i = 0; i <= 10; i++) begin
            cyc();
            ep = exp_pmod(ph, 1'b0, ea0, ea1, ebr);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t5_show_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
        end
        enable = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cyc();
            eack = (j == 5);
            checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL t5_off_pmod j=%0d got %h exp 00", j, pmod); end
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL t5_off_tick j=%0d got %b exp 0", j, frame_tick); end
            checks++; if (load_ack !== eack) begin errors++; $display("FAIL t5_off_ack j=%0d got %b exp %b", j, load_ack, eack); end
            load = (j == 4);
            if (j == 4) begin seg0 = 7'h4F; seg1 = 7'h66; end
        end
        enable = 1'b1;
        ph = 63;
        ea0 = 7'h4F; ea1 = 7'h66;
        for (int i = 0; i < 64; i++) begin
            cyc();
            ep = exp_pmod(ph, i == 0, ea0, ea1, ebr);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t5_restart_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t5_restart_tick ph=%0d got %b", ph, frame_tick); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL t5_restart_ack ph=%0d got %b exp 0", ph, load_ack); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 45; i++) begin
            cyc();
            ep = exp_pmod(ph, 1'b0, ea0, ea1, ebr);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t6_pre_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
            load = (i == 38);
            if (i == 38) begin seg0 = 7'h3F; seg1 = 7'h3F; end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL t6_rst_pmod got %h exp 00", pmod); end
        checks++; if ({load_ack, frame_tick} !== 2'b00) begin errors++; $display("FAIL t6_rst_flags got %b exp 00", {load_ack, frame_tick}); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL t6_hold_pmod got %h exp 00", pmod); end
        #3 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cyc();
            checks++; if (pmod !== 8'h00) begin errors++; $display("FAIL t6_post_pmod j=%0d got %h exp 00", j, pmod); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL t6_post_ack j=%0d got %b exp 0", j, load_ack); end
        end
        enable = 1'b1;
        ph = 63;
        for (int i = 0; i < 64; i++) begin
            cyc();
            ep = exp_pmod(ph, i == 0, 7'h00, 7'h00, ebr);
            checks++; if (pmod !== ep) begin errors++; $display("FAIL t6_scan_pmod ph=%0d got %h exp %h", ph, pmod, ep); end
            checks++; if (frame_tick !== 1'(ph == 0)) begin errors++; $display("FAIL t6_scan_tick ph=%0d got %b", ph, frame_tick); end
            checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL t6_scan_ack ph=%0d got %b exp 0", ph, load_ack); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_blank_patterns();
        test_load_pending();
        test_double_load();
        test_back_to_back_boundary_load();
        test_bright_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
